// File: rtl/ph_out_txn_ctrl.sv
// Host OUT-transaction sequencer: OUT token, DATA0, then wait for the handshake.
// NAK, receive error or timeout retries the whole OUT+DATA0 pair up to MAX_RETRY attempts.
module ph_out_txn_ctrl #(
    parameter int unsigned MAX_RETRY = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  endp_in,
    input  logic [63:0] data_in,
    input  logic        out_done,
    input  logic        rcv_ACK,
    input  logic        rcv_NAK,
    input  logic        rcv_error,
    output logic        send_OUT,
    output logic        send_DATA0,
    output logic [3:0]  endp,
    output logic [63:0] data,
    output logic        rx_listen,
    output logic        busy,
    output logic        txn_done,
    output logic        txn_ok,
    output logic [3:0]  attempts
);

    typedef enum logic [2:0] {
        StIdle,
        StToken,
        StData,
        StWaitHs,
        StFin
    } state_e;

    localparam logic [3:0] MaxRetryW   = 4'(MAX_RETRY);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e     state_q;
    logic [3:0] retry_cnt_q;
    logic [7:0] timeout_cnt_q;

    logic hs_ack;
    logic hs_fail;
    logic last_try;

    // ACK wins over a simultaneous timeout, but not over NAK or error.
    assign hs_ack   = rcv_ACK && !rcv_NAK && !rcv_error;
    assign hs_fail  = rcv_NAK || rcv_error || (timeout_cnt_q == TimeoutLast);
    assign last_try = (retry_cnt_q + 4'd1) == MaxRetryW;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            retry_cnt_q   <= 4'd0;
            timeout_cnt_q <= 8'd0;
            send_OUT      <= 1'b0;
            send_DATA0    <= 1'b0;
            endp          <= 4'd0;
            data          <= 64'd0;
            rx_listen     <= 1'b0;
            busy          <= 1'b0;
            txn_done      <= 1'b0;
            txn_ok        <= 1'b0;
            attempts      <= 4'd0;
        end else begin
            send_OUT   <= 1'b0;
            send_DATA0 <= 1'b0;
            txn_done   <= 1'b0;
            txn_ok     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        endp        <= endp_in;
                        data        <= data_in;
                        retry_cnt_q <= 4'd0;
                        busy        <= 1'b1;
                        send_OUT    <= 1'b1;
                        state_q     <= StToken;
                    end
                end
                // The send request pulse doubles as the first-cycle marker.
                StToken: begin
                    if (out_done && !send_OUT) begin
                        send_DATA0 <= 1'b1;
                        state_q    <= StData;
                    end
                end
                StData: begin
                    if (out_done && !send_DATA0) begin
                        timeout_cnt_q <= 8'd0;
                        rx_listen     <= 1'b1;
                        state_q       <= StWaitHs;
                    end
                end
                StWaitHs: begin
                    timeout_cnt_q <= timeout_cnt_q + 8'd1;
                    if (hs_ack) begin
                        rx_listen <= 1'b0;
                        txn_done  <= 1'b1;
                        txn_ok    <= 1'b1;
                        attempts  <= retry_cnt_q + 4'd1;
                        state_q   <= StFin;
                    end else if (hs_fail) begin
                        rx_listen   <= 1'b0;
                        retry_cnt_q <= retry_cnt_q + 4'd1;
                        if (last_try) begin
                            txn_done <= 1'b1;
                            attempts <= MaxRetryW;
                            state_q  <= StFin;
                        end else begin
                            send_OUT <= 1'b1;
                            state_q  <= StToken;
                        end
                    end
                end
                StFin: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ph_out_txn_ctrl.sv
// Bench for ph_out_txn_ctrl: table of transactions against a sender/receiver model,
// plus hand-written spurious-input and reset-abort sequences.
module tb_ph_out_txn_ctrl;

    localparam int unsigned MaxRetry = 8;
    localparam int unsigned Timeout  = 255;
    localparam int          SendDly  = 20;
    localparam int          ExpGap   = SendDly + 1;

    localparam logic [2:0] KAck    = 3'd0;
    localparam logic [2:0] KNak    = 3'd1;
    localparam logic [2:0] KErr    = 3'd2;
    localparam logic [2:0] KNone   = 3'd3;
    localparam logic [2:0] KAckNak = 3'd4;

    typedef struct {
        logic [3:0]      endp;
        logic [63:0]     data;
        int              n_resp;
        logic [7:0][2:0] kind;
        logic [7:0][7:0] at;
        logic            exp_ok;
        logic [3:0]      exp_att;
        bit              spur;
    } vec_t;

    typedef struct {
        logic        ok;
        logic [3:0]  att;
        logic        busy;
        int          outs;
        int          datas;
        logic [3:0]  endp;
        logic [63:0] data;
    } done_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [3:0]  endp_in;
    logic [63:0] data_in;
    logic        out_done;
    logic        rcv_ACK;
    logic        rcv_NAK;
    logic        rcv_error;
    logic        send_OUT;
    logic        send_DATA0;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        rx_listen;
    logic        busy;
    logic        txn_done;
    logic        txn_ok;
    logic [3:0]  attempts;

    // Model-driven and bench-forced (spurious) stimulus are kept apart and OR-ed.
    logic m_out_done, m_ack, m_nak, m_err;
    logic s_out_done, s_ack;
    assign out_done  = m_out_done | s_out_done;
    assign rcv_ACK   = m_ack | s_ack;
    assign rcv_NAK   = m_nak;
    assign rcv_error = m_err;

    ph_out_txn_ctrl #(
        .MAX_RETRY (MaxRetry),
        .TIMEOUT   (Timeout)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .endp_in    (endp_in),
        .data_in    (data_in),
        .out_done   (out_done),
        .rcv_ACK    (rcv_ACK),
        .rcv_NAK    (rcv_NAK),
        .rcv_error  (rcv_error),
        .send_OUT   (send_OUT),
        .send_DATA0 (send_DATA0),
        .endp       (endp),
        .data       (data),
        .rx_listen  (rx_listen),
        .busy       (busy),
        .txn_done   (txn_done),
        .txn_ok     (txn_ok),
        .attempts   (attempts)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]  resp_k_q[$];
    logic [7:0]  resp_a_q[$];
    int          exp_win_q[$];
    int          win_q[$];
    int          gap_q[$];
    done_t       done_q[$];

    logic [3:0]  cur_endp;
    logic [63:0] cur_data;

    int          od_cnt, win_len, since_out, out_cnt, data_cnt, lat_bad, listen_bad;
    bit          in_hs, fired;
    logic [2:0]  cur_k;
    logic [7:0]  cur_a;
    done_t       mon_rec;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] e, input logic [63:0] d, input logic ok,
                                 input logic [3:0] att, input bit spur);
        vec_t v;
        v.endp    = e;
        v.data    = d;
        v.n_resp  = 0;
        v.kind    = '0;
        v.at      = '0;
        v.exp_ok  = ok;
        v.exp_att = att;
        v.spur    = spur;
        return v;
    endfunction

    function automatic vec_t addr(input vec_t v, input logic [2:0] k, input logic [7:0] a);
        vec_t r = v;
        r.kind[r.n_resp] = k;
        r.at[r.n_resp]   = a;
        r.n_resp++;
        return r;
    endfunction

    // Sender model (out_done SendDly cycles after each request), receiver model
    // (one scripted response per handshake window) and output monitor.
    initial begin
        od_cnt = -1; win_len = 0; since_out = 0; out_cnt = 0; data_cnt = 0;
        lat_bad = 0; listen_bad = 0; in_hs = 0; fired = 0; cur_k = KNone; cur_a = '0;
        m_out_done = 0; m_ack = 0; m_nak = 0; m_err = 0;
        forever begin
            @(negedge clock);
            m_out_done = 0; m_ack = 0; m_nak = 0; m_err = 0;
            if (!reset_n) begin
                od_cnt = -1; in_hs = 0; fired = 0; out_cnt = 0; data_cnt = 0; since_out = 0;
                continue;
            end
            if (send_OUT || send_DATA0) od_cnt = SendDly;
            else if (od_cnt > 0) begin
                od_cnt--;
                if (od_cnt == 0) begin
                    m_out_done = 1;
                    od_cnt = -1;
                end
            end
            if (rx_listen) begin
                if (!in_hs) begin
                    in_hs = 1; win_len = 0; fired = 0;
                    if (resp_k_q.size() != 0) begin
                        cur_k = resp_k_q.pop_front();
                        cur_a = resp_a_q.pop_front();
                    end else begin
                        cur_k = KNone;
                        cur_a = '0;
                    end
                end
                if (!fired && cur_k != KNone && win_len == int'(cur_a)) begin
                    fired = 1;
                    m_ack = (cur_k == KAck) || (cur_k == KAckNak);
                    m_nak = (cur_k == KNak) || (cur_k == KAckNak);
                    m_err = (cur_k == KErr);
                end
                win_len++;
            end else if (in_hs) begin
                in_hs = 0;
                win_q.push_back(win_len);
            end
            if (send_OUT) begin
                out_cnt++;
                since_out = 0;
            end else begin
                since_out++;
            end
            if (send_DATA0) begin
                data_cnt++;
                gap_q.push_back(since_out);
            end
            if ((send_OUT || send_DATA0) && (endp !== cur_endp || data !== cur_data)) lat_bad++;
            if (rx_listen && (send_OUT || send_DATA0 || txn_done)) listen_bad++;
            if (txn_done) begin
                mon_rec.ok    = txn_ok;
                mon_rec.att   = attempts;
                mon_rec.busy  = busy;
                mon_rec.outs  = out_cnt;
                mon_rec.datas = data_cnt;
                mon_rec.endp  = endp;
                mon_rec.data  = data;
                done_q.push_back(mon_rec);
                out_cnt  = 0;
                data_cnt = 0;
            end
        end
    end

    task automatic finish_txn(input vec_t v, input string tag);
        int    waited = 0;
        done_t rec;
        while (done_q.size() == 0 && waited < 6000) begin
            @(negedge clock);
            waited++;
        end
        check({tag, ".done_seen"}, done_q.size() != 0, 1'b1);
        if (done_q.size() != 0) begin
            rec = done_q.pop_front();
            check({tag, ".txn_ok"}, rec.ok, v.exp_ok);
            check({tag, ".attempts"}, rec.att, v.exp_att);
            check({tag, ".busy_at_done"}, rec.busy, 1'b1);
            check({tag, ".n_send_OUT"}, rec.outs, v.n_resp);
            check({tag, ".n_send_DATA0"}, rec.datas, v.n_resp);
            check({tag, ".endp"}, rec.endp, v.endp);
            check({tag, ".data"}, rec.data, v.data);
        end
        check({tag, ".n_data_gaps"}, gap_q.size(), v.n_resp);
        while (gap_q.size() != 0) check({tag, ".out_to_data_gap"}, gap_q.pop_front(), ExpGap);
        check({tag, ".n_windows"}, win_q.size(), exp_win_q.size());
        while (win_q.size() != 0 && exp_win_q.size() != 0)
            check({tag, ".window_len"}, win_q.pop_front(), exp_win_q.pop_front());
        check({tag, ".latched_at_send"}, lat_bad, 0);
        check({tag, ".listen_overlap"}, listen_bad, 0);
        repeat (3) @(negedge clock);
        check({tag, ".idle_busy"}, busy, 1'b0);
        check({tag, ".idle_attempts"}, attempts, v.exp_att);
        check({tag, ".idle_endp"}, endp, v.endp);
        check({tag, ".idle_data"}, data, v.data);
        check({tag, ".no_extra_OUT"}, out_cnt, 0);
        exp_win_q.delete();
        win_q.delete();
        gap_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clock);
        cur_endp = v.endp;
        cur_data = v.data;
        for (int i = 0; i < v.n_resp; i++) begin
            resp_k_q.push_back(v.kind[i]);
            resp_a_q.push_back(v.at[i]);
            exp_win_q.push_back((v.kind[i] == KNone) ? int'(Timeout) : int'(v.at[i]) + 1);
        end
        endp_in = v.endp;
        data_in = v.data;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        endp_in = ~v.endp;
        data_in = ~v.data;
        if (v.spur) begin
            // First TOKEN cycle: early out_done and a stray ACK, then start while busy.
            s_out_done = 1'b1;
            s_ack      = 1'b1;
            @(negedge clock);
            s_out_done = 1'b0;
            s_ack      = 1'b0;
            start      = 1'b1;
            @(negedge clock);
            start      = 1'b0;
        end
        finish_txn(v, tag);
    endtask

    initial begin
        int waited;
        reset_n = 1'b0; start = 1'b0; endp_in = '0; data_in = '0;
        s_out_done = 1'b0; s_ack = 1'b0;
        cur_endp = '0; cur_data = '0;

        vecs[0] = addr(mkv(4'h4, 64'hDEAD_BEEF_0123_4567, 1'b1, 4'd1, 0), KAck, 8'd10);
        vecs[1] = mkv(4'h1, 64'h0123_4567_89AB_CDEF, 1'b1, 4'd3, 0);
        vecs[1] = addr(addr(addr(vecs[1], KNak, 8'd3), KNak, 8'd7), KAck, 8'd2);
        vecs[2] = mkv(4'h7, 64'hFFFF_0000_AAAA_5555, 1'b0, 4'd8, 0);
        for (int i = 0; i < 8; i++) vecs[2] = addr(vecs[2], KNak, 8'd1);
        vecs[3] = addr(addr(mkv(4'hC, 64'h1111_2222_3333_4444, 1'b1, 4'd2, 0), KNone, 8'd0),
                       KAck, 8'd254);
        vecs[4] = mkv(4'h9, 64'h0BAD_F00D_CAFE_0001, 1'b1, 4'd3, 0);
        vecs[4] = addr(addr(addr(vecs[4], KAckNak, 8'd4), KErr, 8'd0), KAck, 8'd0);
        vecs[5] = addr(mkv(4'hA, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 4'd1, 1), KAck, 8'd10);

        repeat (2) @(negedge clock);
        check("reset.ctrl_outs", {send_OUT, send_DATA0, rx_listen, busy, txn_done, txn_ok}, '0);
        check("reset.endp", endp, 4'd0);
        check("reset.data", data, 64'd0);
        check("reset.attempts", attempts, 4'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("idle.busy_no_start", busy, 1'b0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort a transaction while it sits in DATA.
        @(negedge clock);
        cur_endp = 4'h5;
        cur_data = 64'h5555_6666_7777_8888;
        endp_in  = cur_endp;
        data_in  = cur_data;
        start    = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        waited = 0;
        while (data_cnt == 0 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        check("rst.reached_data", data_cnt != 0, 1'b1);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst.ctrl_outs", {send_OUT, send_DATA0, rx_listen, busy, txn_done, txn_ok}, '0);
        check("rst.endp", endp, 4'd0);
        check("rst.data", data, 64'd0);
        check("rst.attempts", attempts, 4'd0);
        resp_k_q.delete();
        resp_a_q.delete();
        exp_win_q.delete();
        repeat (2) @(negedge clock);
        win_q.delete();
        gap_q.delete();
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        check("rst.no_txn_done", done_q.size(), 0);
        check("rst.idle_busy", busy, 1'b0);
        run_vec(vecs[0], "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
